// File: rtl/counter_reg_if.sv
// Bus bundle for counter_reg: count/load controls, load data, counter
// value and terminal count. The staging-register enable and output exist
// only when COUNTER_REG_HOLD_EN is defined.
interface counter_reg_if #(
    parameter int WIDTH = 8
);
    logic             CEP;
    logic             CET;
    logic             _PE;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
`ifdef COUNTER_REG_HOLD_EN
    logic             _EN;
    logic [WIDTH-1:0] HQ;
`endif

    // Driver side: supplies controls and data, observes the counter.
    modport master (
        output CEP,
        output CET,
        output _PE,
        output D,
`ifdef COUNTER_REG_HOLD_EN
        output _EN,
        input  HQ,
`endif
        input  Q,
        input  TC
    );

    // Counter side: consumes controls and data, drives value and TC.
    modport slave (
        input  CEP,
        input  CET,
        input  _PE,
        input  D,
`ifdef COUNTER_REG_HOLD_EN
        input  _EN,
        output HQ,
`endif
        output Q,
        output TC
    );
endinterface

// File: rtl/counter_reg.sv
// counter_reg: WIDTH-bit synchronous binary counter with parallel load and
// ripple-carry terminal count, 74163 style. Two instances cascade into a
// program counter by feeding the low stage's TC into the high stage's CET.
// Optional macro COUNTER_REG_HOLD_EN adds a 74377-style enabled staging
// register (HQ, loaded from D when _EN is low) used to hold the next high byte.
module counter_reg #(
    parameter int WIDTH = 8
) (
    input  logic          CP,
    input  logic          _MR,
    counter_reg_if.slave  bus
);
    logic [WIDTH-1:0] count;

    // Counter: reset beats load, load beats count, count needs both enables.
    always_ff @(posedge CP) begin
        if (!_MR)
            count <= '0;
        else if (!bus._PE)
            count <= bus.D;
        else if (bus.CEP && bus.CET)
            count <= count + 1'b1;
    end

    assign bus.Q  = count;
    // Ripple carry is combinational so a cascaded upper stage sees CET in
    // the same cycle the lower stage sits at all-ones.
    assign bus.TC = bus.CET & (&count);

`ifdef COUNTER_REG_HOLD_EN
    logic [WIDTH-1:0] hold;

    // Staging register: independent of the counter controls.
    always_ff @(posedge CP) begin
        if (!_MR)
            hold <= '0;
        else if (!bus._EN)
            hold <= bus.D;
    end

    assign bus.HQ = hold;
`endif
endmodule

// File: tb/tb_counter_reg.sv
// Directed bench for counter_reg: a low stage under direct control and a
// high stage cascaded from the low stage's TC, sharing CP, _MR and CEP.
module tb_counter_reg;
    logic CP;
    logic _MR;
    int   checks;
    int   errors;

    counter_reg_if #(.WIDTH(8)) bus_lo ();
    counter_reg_if #(.WIDTH(8)) bus_hi ();

    assign bus_hi.CET = bus_lo.TC;
    assign bus_hi.CEP = bus_lo.CEP;

    counter_reg #(.WIDTH(8)) dut_lo (.CP(CP), ._MR(_MR), .bus(bus_lo));
    counter_reg #(.WIDTH(8)) dut_hi (.CP(CP), ._MR(_MR), .bus(bus_hi));

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        _MR = 1'b0;
        bus_lo._PE = 1'b0; bus_lo.D = 8'hA5; bus_lo.CEP = 1'b1; bus_lo.CET = 1'b1;
        bus_hi._PE = 1'b0; bus_hi.D = 8'h5A;
`ifdef COUNTER_REG_HOLD_EN
        bus_lo._EN = 1'b0; bus_hi._EN = 1'b0;
`endif
        tick();
        checks++; if (bus_lo.Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", bus_lo.Q); end
        checks++; if (bus_lo.TC !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", bus_lo.TC); end
        checks++; if (bus_hi.Q !== 8'h00) begin errors++; $display("FAIL reset_hi_q got %h exp 00", bus_hi.Q); end
`ifdef COUNTER_REG_HOLD_EN
        checks++; if (bus_lo.HQ !== 8'h00) begin errors++; $display("FAIL reset_hq got %h exp 00", bus_lo.HQ); end
        bus_lo._EN = 1'b1; bus_hi._EN = 1'b1;
`endif
        _MR = 1'b1;
    endtask

    task automatic test_load_priority();
        bus_hi._PE = 1'b1;
        bus_lo._PE = 1'b0; bus_lo.D = 8'h3C; bus_lo.CEP = 1'b1; bus_lo.CET = 1'b1;
        tick();
        checks++; if (bus_lo.Q !== 8'h3C) begin errors++; $display("FAIL load_over_count got %h exp 3c", bus_lo.Q); end
        bus_lo._PE = 1'b1;
        tick();
        checks++; if (bus_lo.Q !== 8'h3D) begin errors++; $display("FAIL count_1 got %h exp 3d", bus_lo.Q); end
        tick();
        checks++; if (bus_lo.Q !== 8'h3E) begin errors++; $display("FAIL count_2 got %h exp 3e", bus_lo.Q); end
    endtask

    task automatic test_enable_gating();
        bus_lo._PE = 1'b0; bus_lo.D = 8'h10;
        tick();
        bus_lo._PE = 1'b1; bus_lo.CEP = 1'b0; bus_lo.CET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_lo.Q !== 8'h10) begin errors++; $display("FAIL cep_low_hold[%0d] got %h exp 10", i, bus_lo.Q); end
        end
        bus_lo.CEP = 1'b1; bus_lo.CET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_lo.Q !== 8'h10) begin errors++; $display("FAIL cet_low_hold[%0d] got %h exp 10", i, bus_lo.Q); end
        end
    endtask

    task automatic test_wrap_tc();
        bus_lo._PE = 1'b0; bus_lo.D = 8'hFE; bus_lo.CEP = 1'b1; bus_lo.CET = 1'b1;
        tick();
        checks++; if (bus_lo.TC !== 1'b0) begin errors++; $display("FAIL tc_at_fe got %b exp 0", bus_lo.TC); end
        bus_lo._PE = 1'b1;
        tick();
        checks++; if (bus_lo.Q !== 8'hFF) begin errors++; $display("FAIL reach_ff got %h exp ff", bus_lo.Q); end
        checks++; if (bus_lo.TC !== 1'b1) begin errors++; $display("FAIL tc_ff_cet1 got %b exp 1", bus_lo.TC); end
        bus_lo.CET = 1'b0; #1;
        checks++; if (bus_lo.TC !== 1'b0) begin errors++; $display("FAIL tc_ff_cet0 got %b exp 0", bus_lo.TC); end
        bus_lo.CET = 1'b1; bus_lo.CEP = 1'b0; #1;
        checks++; if (bus_lo.TC !== 1'b1) begin errors++; $display("FAIL tc_ignores_cep got %b exp 1", bus_lo.TC); end
        bus_lo.CEP = 1'b1;
        tick();
        checks++; if (bus_lo.Q !== 8'h00) begin errors++; $display("FAIL wrap_q got %h exp 00", bus_lo.Q); end
        checks++; if (bus_lo.TC !== 1'b0) begin errors++; $display("FAIL wrap_tc got %b exp 0", bus_lo.TC); end
    endtask

    task automatic test_cascade();
        bus_lo.CEP = 1'b0; bus_lo.CET = 1'b1;
        bus_lo._PE = 1'b0; bus_lo.D = 8'hFF;
        bus_hi._PE = 1'b0; bus_hi.D = 8'h12;
        tick();
        bus_lo._PE = 1'b1; bus_hi._PE = 1'b1; bus_lo.CEP = 1'b1; #1;
        checks++; if ({bus_hi.Q, bus_lo.Q} !== 16'h12FF) begin errors++; $display("FAIL cascade_load got %h exp 12ff", {bus_hi.Q, bus_lo.Q}); end
        tick();
        checks++; if ({bus_hi.Q, bus_lo.Q} !== 16'h1300) begin errors++; $display("FAIL cascade_carry got %h exp 1300", {bus_hi.Q, bus_lo.Q}); end
        tick();
        checks++; if ({bus_hi.Q, bus_lo.Q} !== 16'h1301) begin errors++; $display("FAIL cascade_next got %h exp 1301", {bus_hi.Q, bus_lo.Q}); end
    endtask

    task automatic test_reset_mid();
        _MR = 1'b0; bus_lo._PE = 1'b0; bus_lo.D = 8'h55;
        tick();
        checks++; if ({bus_hi.Q, bus_lo.Q} !== 16'h0000) begin errors++; $display("FAIL reset_over_load got %h exp 0000", {bus_hi.Q, bus_lo.Q}); end
        _MR = 1'b1; bus_lo._PE = 1'b1;
        tick();
        checks++; if (bus_lo.Q !== 8'h01) begin errors++; $display("FAIL count_after_reset got %h exp 01", bus_lo.Q); end
    endtask

`ifdef COUNTER_REG_HOLD_EN
    task automatic test_staging();
        logic [7:0] q_before;
        bus_lo.CEP = 1'b0; bus_lo._PE = 1'b1;
        q_before = bus_lo.Q;
        bus_lo._EN = 1'b0; bus_lo.D = 8'h7E;
        tick();
        checks++; if (bus_lo.HQ !== 8'h7E) begin errors++; $display("FAIL stage_load got %h exp 7e", bus_lo.HQ); end
        checks++; if (bus_lo.Q !== q_before) begin errors++; $display("FAIL stage_q_untouched got %h exp %h", bus_lo.Q, q_before); end
        bus_lo._EN = 1'b1; bus_lo.D = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_lo.HQ !== 8'h7E) begin errors++; $display("FAIL stage_hold[%0d] got %h exp 7e", i, bus_lo.HQ); end
        end
        bus_lo.D = bus_lo.HQ; bus_lo._PE = 1'b0;
        tick();
        checks++; if (bus_lo.Q !== 8'h7E) begin errors++; $display("FAIL load_from_hq got %h exp 7e", bus_lo.Q); end
        bus_lo._PE = 1'b1;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        _MR = 1'b1;
        bus_lo.CEP = 1'b0; bus_lo.CET = 1'b0; bus_lo._PE = 1'b1; bus_lo.D = '0;
        bus_hi._PE = 1'b1; bus_hi.D = '0;
`ifdef COUNTER_REG_HOLD_EN
        bus_lo._EN = 1'b1; bus_hi._EN = 1'b1;
`endif
        #2;
        test_reset();
        test_load_priority();
        test_enable_gating();
        test_wrap_tc();
        test_cascade();
        test_reset_mid();
`ifdef COUNTER_REG_HOLD_EN
        test_staging();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
